// File: rtl/alu_issue.sv
// alu_issue: two-stage issue/execute front end for an external 8-bit ALU.
// Holds an 8x8 register file with r0 hardwired to zero.
// Optional feature: define ALU_ISSUE_FWD_EN to forward alu_result into a
// dependent instruction instead of stalling it for one cycle.
module alu_issue (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_op,
  input  logic [2:0] in_rd,
  input  logic [2:0] in_rs1,
  input  logic [2:0] in_rs2,
  input  logic       in_imm_en,
  input  logic [7:0] in_imm,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_sel,
  input  logic [7:0] alu_result,
  input  logic       alu_zero,
  output logic       wb_valid,
  output logic [2:0] wb_rd,
  output logic [7:0] wb_data,
  output logic       wb_zero
);

  logic [7:0] rf [8];
  logic       ex_valid;
  logic [2:0] ex_rd;
  logic       hazard_a;
  logic       hazard_b;
  logic       accept;
  logic [7:0] op_a;
  logic [7:0] op_b;

  // RAW detection against the instruction currently in EX (r0 never hazards)
  always_comb begin
    hazard_a = ex_valid && (ex_rd != '0) && (in_rs1 == ex_rd);
    hazard_b = ex_valid && (ex_rd != '0) && !in_imm_en && (in_rs2 == ex_rd);
  end

`ifdef ALU_ISSUE_FWD_EN
  // Operand select with forwarding of the EX result; never stalls
  always_comb begin
    op_a     = hazard_a ? alu_result : rf[in_rs1];
    op_b     = in_imm_en ? in_imm : (hazard_b ? alu_result : rf[in_rs2]);
    in_ready = rst_n;
  end
`else
  // Operand select from the register file; a hazard costs one bubble cycle,
  // after which the EX result has been written back and is read normally
  always_comb begin
    op_a     = rf[in_rs1];
    op_b     = in_imm_en ? in_imm : rf[in_rs2];
    in_ready = rst_n && !(in_valid && (hazard_a || hazard_b));
  end
`endif

  // Handshake
  always_comb begin
    accept = in_valid && in_ready;
  end

  // Pipeline state: EX registers (alu_* double as EX operands) and writeback
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 8; i++) rf[i] <= '0;
      ex_valid <= 1'b0;
      ex_rd    <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_sel  <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      wb_zero  <= 1'b0;
    end else begin
      ex_valid <= accept;
      if (accept) begin
        ex_rd   <= in_rd;
        alu_a   <= op_a;
        alu_b   <= op_b;
        alu_sel <= in_op;
      end
      wb_valid <= ex_valid;
      if (ex_valid) begin
        wb_rd   <= ex_rd;
        wb_data <= alu_result;
        wb_zero <= alu_zero;
        if (ex_rd != '0) rf[ex_rd] <= alu_result;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed testbench for alu_issue with a small add/sub ALU model attached.
module tb_alu_issue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_op;
  logic [2:0] in_rd;
  logic [2:0] in_rs1;
  logic [2:0] in_rs2;
  logic       in_imm_en;
  logic [7:0] in_imm;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_sel;
  logic [7:0] alu_result;
  logic       alu_zero;
  logic       wb_valid;
  logic [2:0] wb_rd;
  logic [7:0] wb_data;
  logic       wb_zero;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  alu_issue dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm_en(in_imm_en), .in_imm(in_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_zero(wb_zero)
  );

  always #5 clk = ~clk;

  // External ALU: 0000 add, 0001 sub
  always_comb begin
    alu_result = (alu_sel == 4'b0001) ? (alu_a - alu_b) : (alu_a + alu_b);
    alu_zero   = (alu_result == 8'h00);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    in_op     = '0;
    in_rd     = '0;
    in_rs1    = '0;
    in_rs2    = '0;
    in_imm_en = 1'b0;
    in_imm    = '0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic imm_en, input logic [7:0] imm);
    in_valid  = 1'b1;
    in_op     = op;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm_en = imm_en;
    in_imm    = imm;
  endtask

  // One isolated instruction: accept, EX operands, single writeback pulse
  task automatic run_single(input string tag, input logic [3:0] op, input logic [2:0] rd,
                            input logic [2:0] rs1, input logic [2:0] rs2, input logic imm_en,
                            input logic [7:0] imm, input logic [7:0] exp_a,
                            input logic [7:0] exp_b, input logic [7:0] exp_data,
                            input logic exp_zero);
    issue(op, rd, rs1, rs2, imm_en, imm);
    #1;
    check({tag, " in_ready"}, in_ready, 1);
    step();
    idle();
    check({tag, " alu_a"}, alu_a, exp_a);
    check({tag, " alu_b"}, alu_b, exp_b);
    check({tag, " alu_sel"}, alu_sel, op);
    check({tag, " wb_valid early"}, wb_valid, 0);
    step();
    check({tag, " wb_valid"}, wb_valid, 1);
    check({tag, " wb_rd"}, wb_rd, rd);
    check({tag, " wb_data"}, wb_data, exp_data);
    check({tag, " wb_zero"}, wb_zero, exp_zero);
    step();
    check({tag, " wb_valid pulse"}, wb_valid, 0);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    step();
    step();
    // Reset state
    check("rst in_ready", in_ready, 0);
    check("rst wb_valid", wb_valid, 0);
    check("rst alu_a", alu_a, 0);
    check("rst alu_b", alu_b, 0);
    check("rst alu_sel", alu_sel, 0);
    check("rst wb_data", wb_data, 0);
    rst_n = 1'b1;
    #1;
    check("post-rst in_ready", in_ready, 1);

    // r1 = r0 + 5, r2 = r0 + 3
    run_single("r1=5", 4'b0000, 3'd1, 3'd0, 3'd0, 1'b1, 8'h05, 8'h00, 8'h05, 8'h05, 1'b0);
    run_single("r2=3", 4'b0000, 3'd2, 3'd0, 3'd0, 1'b1, 8'h03, 8'h00, 8'h03, 8'h03, 1'b0);

    // Back-to-back dependent pair: r3 = r1 + r2, r4 = r3 - r2
    issue(4'b0000, 3'd3, 3'd1, 3'd2, 1'b0, 8'h00);
    #1;
    check("dep1 in_ready", in_ready, 1);
    step();
    issue(4'b0001, 3'd4, 3'd3, 3'd2, 1'b0, 8'h00);
    #1;
    check("dep1 alu_a", alu_a, 8'h05);
    check("dep1 alu_b", alu_b, 8'h03);
`ifdef ALU_ISSUE_FWD_EN
    check("dep2 in_ready fwd", in_ready, 1);
    step();
    idle();
    check("dep1 wb_valid", wb_valid, 1);
    check("dep1 wb_rd", wb_rd, 3);
    check("dep1 wb_data", wb_data, 8'h08);
`else
    check("dep2 in_ready stall", in_ready, 0);
    step();
    check("dep1 wb_valid", wb_valid, 1);
    check("dep1 wb_rd", wb_rd, 3);
    check("dep1 wb_data", wb_data, 8'h08);
    check("dep2 in_ready retry", in_ready, 1);
    step();
    idle();
    check("bubble wb_valid", wb_valid, 0);
`endif
    check("dep2 alu_a", alu_a, 8'h08);
    check("dep2 alu_b", alu_b, 8'h03);
    check("dep2 alu_sel", alu_sel, 4'b0001);
    step();
    check("dep2 wb_valid", wb_valid, 1);
    check("dep2 wb_rd", wb_rd, 4);
    check("dep2 wb_data", wb_data, 8'h05);
    step();
    check("dep2 wb_valid pulse", wb_valid, 0);

    // r0 write is reported but discarded
    run_single("r0=FF", 4'b0000, 3'd0, 3'd0, 3'd0, 1'b1, 8'hFF, 8'h00, 8'hFF, 8'hFF, 1'b0);
    run_single("r6=r0+1", 4'b0000, 3'd6, 3'd0, 3'd0, 1'b1, 8'h01, 8'h00, 8'h01, 8'h01, 1'b0);

    // Zero flag
    run_single("r5=r1-r1", 4'b0001, 3'd5, 3'd1, 3'd1, 1'b0, 8'h00, 8'h05, 8'h05, 8'h00, 1'b1);

    // Idle gap: alu_* hold, no extra writeback pulses
    run_single("r7=r1+2", 4'b0000, 3'd7, 3'd1, 3'd0, 1'b1, 8'h02, 8'h05, 8'h02, 8'h07, 1'b0);
    step();
    check("gap wb_valid", wb_valid, 0);
    check("gap alu_a", alu_a, 8'h05);
    check("gap alu_b", alu_b, 8'h02);
    run_single("r7-r4", 4'b0001, 3'd7, 3'd7, 3'd4, 1'b0, 8'h00, 8'h07, 8'h05, 8'h02, 1'b0);

    // Reset while an instruction sits in EX
    issue(4'b0000, 3'd6, 3'd0, 3'd0, 1'b1, 8'h09);
    step();
    idle();
    rst_n = 1'b0;
    #1;
    check("midrst in_ready", in_ready, 0);
    step();
    rst_n = 1'b1;
    #1;
    check("midrst wb_valid", wb_valid, 0);
    check("midrst alu_a", alu_a, 0);
    check("midrst in_ready", in_ready, 1);
    step();
    check("midrst wb_valid next", wb_valid, 0);
    for (int i = 1; i < 8; i++) begin
      run_single($sformatf("clr r%0d", i), 4'b0000, 3'(i), 3'(i), 3'd0, 1'b1, 8'h00,
                 8'h00, 8'h00, 8'h00, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
